// File: rtl/counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : counter_pkg
// Brief  : Shared types and width defaults for the counter family
//          (ripple up-counter and sync_down_timer).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package counter_pkg;

  // Default counter/load width used by the down-timer.
  localparam int DEFAULT_WIDTH = 4;

  // Default width of the ripple up-counter.
  localparam int RIPPLE_WIDTH = 4;

  // Default width of the saturating reload-event counter.
  localparam int DEFAULT_RELOAD_CNT_W = 4;

  // Timer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } timer_state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/sync_down_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sync_down_timer
// Brief  : Loadable synchronous down-counter with start/busy/tc handshake,
//          pause/abort control and optional auto-reload. tc is a registered
//          one-cycle pulse that coincides with count reaching 0 (single
//          shot) or with the reload value reappearing (auto-reload).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sync_down_timer
  import counter_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int RELOAD_CNT_W = DEFAULT_RELOAD_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        load_val,
  input  logic                    pause,
  input  logic                    abort,
  input  logic                    reload_en,
  output logic [WIDTH-1:0]        count,
  output logic                    busy,
  output logic                    tc,
  output logic [RELOAD_CNT_W-1:0] reload_cnt
);

  timer_state_t            state;
  timer_state_t            state_n;
  logic [WIDTH-1:0]        reload_q;
  logic [WIDTH-1:0]        reload_n;
  logic [WIDTH-1:0]        count_n;
  logic [RELOAD_CNT_W-1:0] rcnt_n;
  logic                    tc_n;
  logic                    do_load;

  // State register: async reset forces IDLE regardless of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-datapath decode; priority abort > start > pause > decrement.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_q;
    rcnt_n   = reload_cnt;
    tc_n     = 1'b0;
    do_load  = 1'b0;

    unique case (state)
      IDLE: begin
        // pause, abort and reload_en have no meaning before a count starts.
        if (start) begin
          do_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          count_n = '0;
          state_n = IDLE;
        end else if (start) begin
          do_load = 1'b1;
        end else if (pause) begin
          state_n = PAUSED;
        end else if (count > WIDTH'(1)) begin
          count_n = count - WIDTH'(1);
        end else begin
          // Terminal edge: count is 1 here, never 0 while running.
          tc_n = 1'b1;
          if (reload_en) begin
            count_n = reload_q;
            if (reload_cnt != {RELOAD_CNT_W{1'b1}}) begin
              rcnt_n = reload_cnt + RELOAD_CNT_W'(1);
            end
          end else begin
            count_n = '0;
            state_n = IDLE;
          end
        end
      end
      PAUSED: begin
        if (abort) begin
          count_n = '0;
          state_n = IDLE;
        end else if (start) begin
          do_load = 1'b1;
        end else if (!pause) begin
          // Resume edge does not decrement; counting restarts next edge.
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase

    // A (re)start overrides any terminal event decoded above at this edge.
    if (do_load) begin
      rcnt_n = '0;
      if (load_val == '0) begin
        count_n = '0;
        tc_n    = 1'b1;
        state_n = IDLE;
      end else begin
        count_n  = load_val;
        reload_n = load_val;
        tc_n     = 1'b0;
        state_n  = RUN;
      end
    end
  end

  // Datapath registers; busy is registered from the next state so it tracks state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      reload_q   <= '0;
      reload_cnt <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      count      <= count_n;
      reload_q   <= reload_n;
      reload_cnt <= rcnt_n;
      tc         <= tc_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule : sync_down_timer
`default_nettype wire

// File: tb/tb_sync_down_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sync_down_timer
// Brief  : Scoreboard bench for sync_down_timer. The driver applies inputs on
//          the falling edge and pushes the expected post-edge outputs from a
//          behavioural model; the monitor pops one entry per rising edge.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sync_down_timer;

  localparam int W  = 4;
  localparam int RW = 4;
  localparam int RC_MAX = (1 << RW) - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  load_val;
  logic          pause;
  logic          abort;
  logic          reload_en;
  logic [W-1:0]  count;
  logic          busy;
  logic          tc;
  logic [RW-1:0] reload_cnt;

  sync_down_timer #(.WIDTH(W), .RELOAD_CNT_W(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_val   (load_val),
    .pause      (pause),
    .abort      (abort),
    .reload_en  (reload_en),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .reload_cnt (reload_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int c;
    int b;
    int t;
    int r;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: "active" means a count is in progress, "held" means paused.
  bit m_active, m_held, m_tc;
  int m_cnt, m_period, m_reloads;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_held = 0; m_tc = 0;
    m_cnt = 0; m_period = 0; m_reloads = 0;
  endfunction

  function automatic void model_begin(input int n);
    m_reloads = 0;
    m_cnt     = n;
    if (n == 0) begin
      m_tc = 1; m_active = 0; m_held = 0;
    end else begin
      m_period = n; m_active = 1; m_held = 0;
    end
  endfunction

  // One clock edge of the timer's rules.
  function automatic void model_edge(input bit s, input int n, input bit p,
                                     input bit a, input bit re);
    m_tc = 0;
    if (!m_active) begin
      if (s) model_begin(n);
    end else if (a) begin
      m_cnt = 0; m_active = 0; m_held = 0;
    end else if (s) begin
      model_begin(n);
    end else if (m_held) begin
      if (!p) m_held = 0;
    end else if (p) begin
      m_held = 1;
    end else if (m_cnt > 1) begin
      m_cnt = m_cnt - 1;
    end else begin
      m_tc = 1;
      if (re) begin
        m_cnt = m_period;
        m_reloads = (m_reloads + 1 > RC_MAX) ? RC_MAX : m_reloads + 1;
      end else begin
        m_cnt = 0; m_active = 0;
      end
    end
  endfunction

  // Drive one cycle of inputs and queue the expected outputs after the next edge.
  task automatic cyc(input bit s, input int n, input bit p, input bit a,
                     input bit re, input bit rs = 1'b0);
    exp_t e;
    @(negedge clk);
    reset     = rs;
    start     = s;
    load_val  = W'(n);
    pause     = p;
    abort     = a;
    reload_en = re;
    if (rs) model_reset();
    else model_edge(s, n, p, a, re);
    e.c = m_cnt; e.b = int'(m_active); e.t = int'(m_tc); e.r = m_reloads;
    q.push_back(e);
  endtask

  task automatic idle(input int k, input bit re = 1'b0);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, re);
  endtask

  // Monitor: compare every registered output once per rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", int'(count), e.c);
        chk("busy", int'(busy), e.b);
        chk("tc", int'(tc), e.t);
        chk("reload_cnt", int'(reload_cnt), e.r);
      end
    end
  end

  initial begin : driver
    int lv;
    bit re;
    reset = 1'b1; start = 0; load_val = '0; pause = 0; abort = 0; reload_en = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    // Single shot N=4.
    cyc(1, 4, 0, 0, 0);
    idle(6);

    // Auto-reload N=3 for ten cycles, then let it run out.
    cyc(1, 3, 0, 0, 1);
    idle(9, 1'b1);
    idle(5);

    // Pause for three cycles while count is 4.
    cyc(1, 6, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    idle(8);

    // Abort at count 2, then a zero-length start.
    cyc(1, 4, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    idle(3);

    // Restart on the terminal edge.
    cyc(1, 3, 0, 0, 0);
    idle(2);
    cyc(1, 7, 0, 0, 0);
    idle(9);

    // Reload counter saturation with N=1.
    cyc(1, 1, 0, 0, 1);
    idle(20, 1'b1);
    idle(3);

    // Asynchronous reset while running at count 5.
    cyc(1, 9, 0, 0, 0);
    idle(4);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_tc", int'(tc), 0);
    chk("async_reload_cnt", int'(reload_cnt), 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(3);

    // Randomized traffic.
    re = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) re = ~re;
      if ($urandom_range(0, 3) == 0) lv = int'($urandom_range(0, 2));
      else lv = int'($urandom_range(0, 15));
      cyc(($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 39) == 0), re, ($urandom_range(0, 499) == 0));
    end
    idle(2);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_down_timer
`default_nettype wire
